iomem_uart_master: RTL

- Debug bridge that acts as an initiator on the picosoc iomem bus. It is the opposite end from the peripheral responders, such as the GPIO register at 0x03xxxxxx.
- It receives framed read/write commands over its own 8N1 UART, issues one iomem transaction per command, and returns the result or status bytes over the UART.
- It sits in the top level beside the SoC and drives a shared iomem decode. This lets the host poke peripherals without firmware.

---
 rtl/iomem_uart_master.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/iomem_uart_master.sv
// UART-driven iomem bus initiator: framed R/W commands in, one bus
// transaction per command, result or status bytes back out.
module iomem_uart_master #(
    parameter int unsigned CLK_DIV = 104,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_pll,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [19:0] TMO_M1  = 20'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, STRB, DATA, EXEC, REPLY
    } state_t;

    // [0],[1]: synchroniser, [2]: previous value for edge detect
    logic [2:0]  rx_sync;
    logic        rx_act;
    logic [15:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_in;
    logic        rx_fire;

    assign rx_in   = rx_sync[1];
    assign rx_fire = rx_act && rx_cnt == 16'd0
                  && rx_bit == 4'd9 && rx_in;

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            rx_sync <= 3'b111;
            rx_act  <= 1'b0;
            rx_cnt  <= 16'd0;
            rx_bit  <= 4'd0;
            rx_sh   <= 8'd0;
        end else begin
            rx_sync <= {rx_sync[1:0], ser_rx};
            if (!rx_act) begin
                if (rx_sync[2] && !rx_in) begin
                    rx_act <= 1'b1;
                    rx_cnt <= HALF_M1;
                    rx_bit <= 4'd0;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= DIV_M1;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0 && rx_in)
                    rx_act <= 1'b0;
                if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
                    rx_sh <= {rx_in, rx_sh[7:1]};
                if (rx_bit == 4'd9)
                    rx_act <= 1'b0;
            end
        end
    end

    logic        tx_act;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_sh;
    logic        tx_end;
    logic        tx_ready;
    logic        tx_load;
    logic [7:0]  tx_byte;

    // ready in the last stop-bit cycle so replies run back-to-back
    assign tx_end   = tx_act && tx_bit == 4'd9 && tx_cnt == DIV_M1;
    assign tx_ready = !tx_act || tx_end;
    assign ser_tx   = tx_act ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            tx_act <= 1'b0;
            tx_cnt <= 16'd0;
            tx_bit <= 4'd0;
            tx_sh  <= 10'h3ff;
        end else if (tx_load) begin
            tx_act <= 1'b1;
            tx_cnt <= 16'd0;
            tx_bit <= 4'd0;
            tx_sh  <= {1'b1, tx_byte, 1'b0};
        end else if (tx_act) begin
            if (tx_cnt == DIV_M1) begin
                tx_cnt <= 16'd0;
                tx_bit <= tx_bit + 4'd1;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bit == 4'd9)
                    tx_act <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    state_t      state, state_d;
    logic        is_wr, is_wr_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  wstrb_d;
    logic        valid_d;
    logic [19:0] timer, timer_d;
    logic [31:0] rep, rep_d;
    logic [2:0]  rep_n, rep_n_d;

    assign tx_byte = rep[31:24];
    assign busy    = (state != IDLE) || rx_fire;

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            state   <= IDLE;
            is_wr   <= 1'b0;
            cnt     <= 2'd0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            m_wstrb <= 4'd0;
            m_valid <= 1'b0;
            timer   <= 20'd0;
            rep     <= 32'd0;
            rep_n   <= 3'd0;
        end else begin
            state   <= state_d;
            is_wr   <= is_wr_d;
            cnt     <= cnt_d;
            m_addr  <= addr_d;
            m_wdata <= wdata_d;
            m_wstrb <= wstrb_d;
            m_valid <= valid_d;
            timer   <= timer_d;
            rep     <= rep_d;
            rep_n   <= rep_n_d;
        end
    end

    always_comb begin
        state_d = state;
        is_wr_d = is_wr;
        cnt_d   = cnt;
        addr_d  = m_addr;
        wdata_d = m_wdata;
        wstrb_d = m_wstrb;
        valid_d = m_valid;
        timer_d = timer;
        rep_d   = rep;
        rep_n_d = rep_n;
        tx_load = 1'b0;
        unique case (state)
            IDLE: if (rx_fire) begin
                cnt_d = 2'd0;
                if (rx_sh == 8'h57) begin
                    state_d = ADDR;
                    is_wr_d = 1'b1;
                end else if (rx_sh == 8'h52) begin
                    state_d = ADDR;
                    is_wr_d = 1'b0;
                    wstrb_d = 4'd0;
                end else begin
                    state_d = REPLY;
                    rep_d   = {8'h3f, 24'd0};
                    rep_n_d = 3'd1;
                end
            end
            ADDR: if (rx_fire) begin
                addr_d = {m_addr[23:0], rx_sh};
                cnt_d  = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    if (is_wr) begin
                        state_d = STRB;
                    end else begin
                        state_d = EXEC;
                        valid_d = 1'b1;
                        timer_d = 20'd0;
                    end
                end
            end
            STRB: if (rx_fire) begin
                wstrb_d = rx_sh[3:0];
                cnt_d   = 2'd0;
                state_d = DATA;
            end
            DATA: if (rx_fire) begin
                wdata_d = {m_wdata[23:0], rx_sh};
                cnt_d   = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_d = EXEC;
                    valid_d = 1'b1;
                    timer_d = 20'd0;
                end
            end
            EXEC: begin
                if (m_ready) begin
                    valid_d = 1'b0;
                    state_d = REPLY;
                    rep_d   = is_wr ? {8'h4b, 24'd0} : m_rdata;
                    rep_n_d = is_wr ? 3'd1 : 3'd4;
                end else if (timer == TMO_M1) begin
                    valid_d = 1'b0;
                    state_d = REPLY;
                    rep_d   = {8'h54, 24'd0};
                    rep_n_d = 3'd1;
                end else begin
                    timer_d = timer + 20'd1;
                end
            end
            REPLY: begin
                if (rep_n != 3'd0) begin
                    if (tx_ready) begin
                        tx_load = 1'b1;
                        rep_d   = {rep[23:0], 8'd0};
                        rep_n_d = rep_n - 3'd1;
                    end
                end else if (tx_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
